// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: operand forwarding, immediate extension and ALU input
// formation, with stall/flush control and a saturating bubble counter.
module id_ex_stage #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned BCNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              dvalid,
  input  logic [XLEN-1:0]   drs_data,
  input  logic [XLEN-1:0]   drt_data,
  input  logic [15:0]       dimm,
  input  logic [4:0]        dshamt,
  input  logic [3:0]        daluc,
  input  logic              daluimm,
  input  logic              dshift,
  input  logic              dsext,
  input  logic              dwreg,
  input  logic              dm2reg,
  input  logic              dwmem,
  input  logic [4:0]        drn,
  input  logic [1:0]        fwda,
  input  logic [1:0]        fwdb,
  input  logic [XLEN-1:0]   ex_r,
  input  logic [XLEN-1:0]   mem_r,
  input  logic [XLEN-1:0]   mem_mdata,
  output logic [XLEN-1:0]   ea,
  output logic [XLEN-1:0]   eb,
  output logic [3:0]        ealuc,
  output logic [XLEN-1:0]   estore,
  output logic              ewreg,
  output logic              em2reg,
  output logic              ewmem,
  output logic [4:0]        ern,
  output logic              evalid,
  output logic [BCNT_W-1:0] bubble_cnt
);

  localparam int unsigned IMM_W = 16;

  logic [XLEN-1:0]   fa, fb, imm_ext;
  logic              load_bubble;

  logic [XLEN-1:0]   ea_d, ea_q, eb_d, eb_q, estore_d, estore_q;
  logic [3:0]        ealuc_d, ealuc_q;
  logic              ewreg_d, ewreg_q, em2reg_d, em2reg_q, ewmem_d, ewmem_q;
  logic              evalid_d, evalid_q;
  logic [4:0]        ern_d, ern_q;
  logic [BCNT_W-1:0] bubble_cnt_d, bubble_cnt_q;

  // Operand forwarding muxes
  always_comb begin
    fa = drs_data;
    unique case (fwda)
      2'b00: fa = drs_data;
      2'b01: fa = ex_r;
      2'b10: fa = mem_r;
      2'b11: fa = mem_mdata;
      default: fa = drs_data;
    endcase
    fb = drt_data;
    unique case (fwdb)
      2'b00: fb = drt_data;
      2'b01: fb = ex_r;
      2'b10: fb = mem_r;
      2'b11: fb = mem_mdata;
      default: fb = drt_data;
    endcase
    imm_ext = dsext ? {{(XLEN-IMM_W){dimm[IMM_W-1]}}, dimm} : {{(XLEN-IMM_W){1'b0}}, dimm};
  end

  // Next-state selection; flush beats stall, a stalled stage holds everything
  always_comb begin
    ea_d         = ea_q;
    eb_d         = eb_q;
    ealuc_d      = ealuc_q;
    estore_d     = estore_q;
    ewreg_d      = ewreg_q;
    em2reg_d     = em2reg_q;
    ewmem_d      = ewmem_q;
    ern_d        = ern_q;
    evalid_d     = evalid_q;
    bubble_cnt_d = bubble_cnt_q;

    load_bubble = flush || (!stall && !dvalid);

    if (load_bubble) begin
      ea_d     = '0;
      eb_d     = '0;
      ealuc_d  = '0;
      estore_d = '0;
      ewreg_d  = 1'b0;
      em2reg_d = 1'b0;
      ewmem_d  = 1'b0;
      ern_d    = '0;
      evalid_d = 1'b0;
      if (bubble_cnt_q != {BCNT_W{1'b1}}) begin
        bubble_cnt_d = bubble_cnt_q + BCNT_W'(1);
      end
    end else if (!stall) begin
      ea_d     = dshift ? XLEN'(dshamt) : fa;
      eb_d     = daluimm ? imm_ext : fb;
      ealuc_d  = daluc;
      estore_d = fb;
      ewreg_d  = dwreg;
      em2reg_d = dm2reg;
      ewmem_d  = dwmem;
      ern_d    = drn;
      evalid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ea_q         <= '0;
      eb_q         <= '0;
      ealuc_q      <= '0;
      estore_q     <= '0;
      ewreg_q      <= 1'b0;
      em2reg_q     <= 1'b0;
      ewmem_q      <= 1'b0;
      ern_q        <= '0;
      evalid_q     <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      ea_q         <= ea_d;
      eb_q         <= eb_d;
      ealuc_q      <= ealuc_d;
      estore_q     <= estore_d;
      ewreg_q      <= ewreg_d;
      em2reg_q     <= em2reg_d;
      ewmem_q      <= ewmem_d;
      ern_q        <= ern_d;
      evalid_q     <= evalid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ea         = ea_q;
  assign eb         = eb_q;
  assign ealuc      = ealuc_q;
  assign estore     = estore_q;
  assign ewreg      = ewreg_q;
  assign em2reg     = em2reg_q;
  assign ewmem      = ewmem_q;
  assign ern        = ern_q;
  assign evalid     = evalid_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage (BCNT_W = 4): directed plan scenarios plus randomized
// traffic, every cycle compared against a behavioural model of the stage.
module tb_id_ex_stage;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BCNT_W = 4;
  localparam int          CNT_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, stall, flush, dvalid;
  logic [31:0]       drs_data, drt_data, ex_r, mem_r, mem_mdata;
  logic [15:0]       dimm;
  logic [4:0]        dshamt, drn, ern;
  logic [3:0]        daluc, ealuc;
  logic              daluimm, dshift, dsext, dwreg, dm2reg, dwmem;
  logic [1:0]        fwda, fwdb;
  logic [31:0]       ea, eb, estore;
  logic              ewreg, em2reg, ewmem, evalid;
  logic [BCNT_W-1:0] bubble_cnt;

  id_ex_stage #(.XLEN(XLEN), .BCNT_W(BCNT_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .dvalid(dvalid),
    .drs_data(drs_data), .drt_data(drt_data), .dimm(dimm), .dshamt(dshamt),
    .daluc(daluc), .daluimm(daluimm), .dshift(dshift), .dsext(dsext),
    .dwreg(dwreg), .dm2reg(dm2reg), .dwmem(dwmem), .drn(drn),
    .fwda(fwda), .fwdb(fwdb), .ex_r(ex_r), .mem_r(mem_r), .mem_mdata(mem_mdata),
    .ea(ea), .eb(eb), .ealuc(ealuc), .estore(estore), .ewreg(ewreg),
    .em2reg(em2reg), .ewmem(ewmem), .ern(ern), .evalid(evalid),
    .bubble_cnt(bubble_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the stage should hold after the last edge
  logic [31:0] m_ea, m_eb, m_store;
  logic [3:0]  m_aluc;
  logic [4:0]  m_rn;
  logic        m_wreg, m_m2reg, m_wmem, m_valid;
  int          m_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_bubble();
    m_ea = 0; m_eb = 0; m_store = 0; m_aluc = 0; m_rn = 0;
    m_wreg = 0; m_m2reg = 0; m_wmem = 0; m_valid = 0;
  endtask

  // Apply the stage's update rules to the inputs currently on the pins
  task automatic model_edge();
    logic [31:0] src [4];
    logic [31:0] fa, fb, imm;
    src[0] = drs_data; src[1] = ex_r; src[2] = mem_r; src[3] = mem_mdata;
    fa = src[fwda];
    src[0] = drt_data;
    fb = src[fwdb];
    imm = {16'h0000, dimm};
    if (dsext && dimm[15]) imm = imm + 32'hFFFF_0000;
    if (rst) begin
      model_bubble();
      m_cnt = 0;
    end else if (flush || (!stall && !dvalid)) begin
      model_bubble();
      if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
    end else if (!stall) begin
      m_ea    = dshift ? 32'(dshamt) : fa;
      m_eb    = daluimm ? imm : fb;
      m_store = fb;
      m_aluc  = daluc;
      m_rn    = drn;
      m_wreg  = dwreg; m_m2reg = dm2reg; m_wmem = dwmem;
      m_valid = 1'b1;
    end
  endtask

  // Called at a negedge with inputs set: clock one edge, then compare everything
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check("ea", ea, m_ea);
    check("eb", eb, m_eb);
    check("ealuc", 32'(ealuc), 32'(m_aluc));
    check("estore", estore, m_store);
    check("ewreg", 32'(ewreg), 32'(m_wreg));
    check("em2reg", 32'(em2reg), 32'(m_m2reg));
    check("ewmem", 32'(ewmem), 32'(m_wmem));
    check("ern", 32'(ern), 32'(m_rn));
    check("evalid", 32'(evalid), 32'(m_valid));
    check("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
  endtask

  task automatic rand_data();
    drs_data = $urandom; drt_data = $urandom; ex_r = $urandom;
    mem_r = $urandom; mem_mdata = $urandom;
    dimm = 16'($urandom); dshamt = 5'($urandom); daluc = 4'($urandom);
    daluimm = 1'($urandom); dshift = 1'($urandom); dsext = 1'($urandom);
    dwreg = 1'($urandom); dm2reg = 1'($urandom); dwmem = 1'($urandom);
    drn = 5'($urandom); fwda = 2'($urandom); fwdb = 2'($urandom);
  endtask

  task automatic plain_inst();
    rst = 0; stall = 0; flush = 0; dvalid = 1;
    dshift = 0; daluimm = 0; dsext = 0; fwda = 0; fwdb = 0;
    dwreg = 1; dm2reg = 0; dwmem = 0; drn = 5'd3; daluc = 4'd0;
  endtask

  int cnt_before;

  initial begin
    rst = 1; stall = 0; flush = 0; dvalid = 0;
    rand_data();
    m_cnt = 0;
    model_bubble();
    @(negedge clk);
    @(negedge clk);

    // Reset wins over stall and a valid instruction
    rst = 1; stall = 1; dvalid = 1;
    step();
    check("rst_evalid", 32'(evalid), 32'd0);
    check("rst_cnt", 32'(bubble_cnt), 32'd0);

    // Immediate add, sign- and zero-extended
    plain_inst();
    drs_data = 32'h0000_0005; dimm = 16'hFFFE; dsext = 1; daluimm = 1;
    step();
    check("imm_sx_ea", ea, 32'h0000_0005);
    check("imm_sx_eb", eb, 32'hFFFF_FFFE);
    check("imm_sx_valid", 32'(evalid), 32'd1);
    dsext = 0;
    step();
    check("imm_zx_eb", eb, 32'h0000_FFFE);

    // Shift uses shamt as a; then lui-style zero-extended immediate
    plain_inst();
    dshift = 1; dshamt = 5'd4; drt_data = 32'h0000_000F; daluc = 4'b0011;
    step();
    check("sh_ea", ea, 32'h0000_0004);
    check("sh_eb", eb, 32'h0000_000F);
    plain_inst();
    dimm = 16'h1234; daluimm = 1; daluc = 4'b0110;
    step();
    check("lui_eb", eb, 32'h0000_1234);
    check("lui_aluc", 32'(ealuc), 32'h6);

    // Forwarding from EX and MEM
    fwda = 2'b01; ex_r = 32'hAAAA_0000; fwdb = 2'b11; mem_mdata = 32'h1234_5678;
    step();
    check("fwd_ea_ex", ea, 32'hAAAA_0000);
    check("fwd_eb_imm", eb, 32'h0000_1234);
    check("fwd_store", estore, 32'h1234_5678);
    fwda = 2'b10; mem_r = 32'h0000_0055;
    step();
    check("fwd_ea_mem", ea, 32'h0000_0055);

    // Stall holds a loaded instruction while inputs churn
    plain_inst();
    drs_data = 32'h1111_2222; drt_data = 32'h3333_4444; daluc = 4'd2;
    dwmem = 1; drn = 5'd7;
    step();
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      rand_data();
      dvalid = 1'($urandom); stall = 1; flush = 0; rst = 0;
      step();
      check("stall_ea", ea, 32'h1111_2222);
      check("stall_eb", eb, 32'h3333_4444);
      check("stall_ern", 32'(ern), 32'd7);
      check("stall_cnt", 32'(bubble_cnt), 32'(cnt_before));
    end
    stall = 1; flush = 1;
    step();
    check("flush_evalid", 32'(evalid), 32'd0);
    check("flush_ewreg", 32'(ewreg), 32'd0);
    check("flush_ewmem", 32'(ewmem), 32'd0);
    check("flush_cnt", 32'(bubble_cnt), 32'(cnt_before + 1));

    // Counter saturates, then clears on reset
    stall = 0; flush = 0; dvalid = 0;
    for (int i = 0; i < 20; i++) begin
      rand_data();
      step();
    end
    check("sat_cnt", 32'(bubble_cnt), 32'd15);
    rst = 1;
    step();
    check("sat_rst_cnt", 32'(bubble_cnt), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_data();
      rst    = ($urandom_range(0, 63) == 0);
      flush  = ($urandom_range(0, 7) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      dvalid = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
